// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: handshake, payload and status bundle for one pipeline stage boundary
interface pipe_stage_skid_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occ;
    logic [CNT_W-1:0] stall_cnt;
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occ, stall_cnt
    );
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occ, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with optional skid entry, flush and stall counter
module pipe_stage_skid #(
    parameter int WIDTH = 64,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              R,
    pipe_stage_skid_if.slave s
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_main, r_skid, w_main_n, w_skid_n;
    logic [CNT_W-1:0] r_cnt;
    logic             w_in_ready, w_out_valid, w_in_fire, w_out_fire;

    assign w_out_valid = r_state != EMPTY;
    assign w_in_fire   = s.in_valid & w_in_ready;
    assign w_out_fire  = w_out_valid & s.out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic r_in_ready;
            // ready is registered from the next state so out_ready never reaches in_ready
            always_ff @(posedge clk or posedge R) begin
                if (R) r_in_ready <= 1'b1;
                else   r_in_ready <= w_next != TWO;
            end
            assign w_in_ready = r_in_ready;
        end else begin : g_noskid
            assign w_in_ready = !w_out_valid | s.out_ready;
        end
    endgenerate

    // next-state and register contents; flush wins over both handshakes and leaves a bubble
    always_comb begin
        w_next   = r_state;
        w_main_n = r_main;
        w_skid_n = r_skid;
        if (s.flush) begin
            w_next   = EMPTY;
            w_main_n = '0;
            w_skid_n = '0;
        end else begin
            case (r_state)
                EMPTY: if (w_in_fire) begin
                    w_main_n = s.in_data;
                    w_next   = ONE;
                end
                ONE: if (w_in_fire && w_out_fire) begin
                    w_main_n = s.in_data;
                end else if (w_in_fire) begin
                    w_skid_n = s.in_data;
                    w_next   = TWO;
                end else if (w_out_fire) begin
                    w_main_n = '0;
                    w_next   = EMPTY;
                end
                TWO: if (w_out_fire) begin
                    w_main_n = r_skid;
                    w_skid_n = '0;
                    w_next   = ONE;
                end
                default: w_next = EMPTY;
            endcase
        end
    end

    // state and payload registers; reset discards both entries
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_next;
            r_main  <= w_main_n;
            r_skid  <= w_skid_n;
        end
    end

    // saturating count of cycles the consumer holds off a valid payload, flush cycles included
    always_ff @(posedge clk or posedge R) begin
        if (R)                                        r_cnt <= '0;
        else if (w_out_valid && !s.out_ready && ~&r_cnt) r_cnt <= r_cnt + 1'b1;
    end

    assign s.in_ready  = w_in_ready;
    assign s.out_valid = w_out_valid;
    assign s.out_data  = r_main;
    assign s.occ       = r_state;
    assign s.stall_cnt = r_cnt;
endmodule
